// File: rtl/phase_sequencer_pkg.sv
// Shared constants for the instruction-phase sequencer and the datapath that
// decodes its phase outputs.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        WAIT_IO   = 3'd2,
        WAIT_STEP = 3'd3,
        HALTED    = 3'd4
    } seq_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and the datapath/board.
// The sequencer uses the master side; consumers of the phase enables use slave.
import phase_sequencer_pkg::*;

interface phase_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16
);
    localparam int IW = idx_width(NUM_PHASES);

    logic                  step_mode;
    logic                  step_pulse;
    logic                  pause_req;
    logic                  io_ack;
    logic                  halt;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic [IW-1:0]         phase_idx;
    logic                  phase_start;
    logic                  instr_done;
    logic                  waiting_io;
    logic                  halted;
    logic [CNT_W-1:0]      instr_count;

    modport master (
        input  step_mode, step_pulse, pause_req, io_ack, halt,
        output phase_onehot, phase_idx, phase_start, instr_done,
               waiting_io, halted, instr_count
    );

    modport slave (
        output step_mode, step_pulse, pause_req, io_ack, halt,
        input  phase_onehot, phase_idx, phase_start, instr_done,
               waiting_io, halted, instr_count
    );

endinterface

// File: rtl/phase_sequencer_tick_counter.sv
// Per-phase prescaler. Down-counts from PHASE_TICKS-1 to zero; zero is the
// terminal tick of the phase. term_next tells the parent whether the count
// will sit at terminal after the coming edge, so it can register strobes that
// must coincide with the terminal tick.
import phase_sequencer_pkg::*;

module phase_tick_counter #(
    parameter int PHASE_TICKS = 1000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic freeze,
    output logic terminal,
    output logic term_next
);
    localparam int TW = idx_width(PHASE_TICKS);
    localparam logic [TW-1:0] LOAD = TW'(PHASE_TICKS - 1);

    logic [TW-1:0] cnt_q;

    // Reload on phase entry, hold while frozen, otherwise count down and wrap.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= LOAD;
        end else if (!freeze) begin
            cnt_q <= (cnt_q == '0) ? LOAD : cnt_q - TW'(1);
        end
    end

    assign terminal = (cnt_q == '0);

    // Predict terminal after the next edge from the same controls.
    always_comb begin
        term_next = 1'b0;
        if (clear) begin
            term_next = (LOAD == '0);
        end else if (freeze) begin
            term_next = terminal;
        end else if (terminal) begin
            term_next = (LOAD == '0);
        end else begin
            term_next = (cnt_q == TW'(1));
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase generator: one-hot phase enables with entry strobes,
// programmable phase length, IO wait, single-step, halt latch and a retired
// instruction counter. Everything lives in the clk domain.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | just out of reset, picks free-run or step on the first edge
// RUN       | a phase is active and the tick counter is running
// WAIT_IO   | IO_PHASE held with the tick frozen until io_ack
// WAIT_STEP | between instructions, no phase active, waiting for step_pulse
// HALTED    | stopped for good; only n_reset leaves this state
import phase_sequencer_pkg::*;

module phase_sequencer #(
    parameter int NUM_PHASES  = 4,
    parameter int IO_PHASE    = 2,
    parameter int PHASE_TICKS = 1000,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    phase_sequencer_if.master bus
);
    localparam int IW = idx_width(NUM_PHASES);
    localparam logic [IW-1:0] LAST   = IW'(NUM_PHASES - 1);
    localparam logic [IW-1:0] IO_IDX = IW'(IO_PHASE);

    seq_state_t            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  start_d, done_d, active_d;
    logic                  do_adv, do_bnd;
    logic                  tick_clear, tick_freeze, tick_term, tick_term_next;
    logic [NUM_PHASES-1:0] onehot_d, onehot_q;
    logic [IW-1:0]         idx_out_q;
    logic                  start_q, done_q, waiting_q, halted_q;
    logic [CNT_W-1:0]      count_q, count_d;

    phase_tick_counter #(
        .PHASE_TICKS (PHASE_TICKS)
    ) u_tick (
        .clk       (clk),
        .n_reset   (n_reset),
        .clear     (tick_clear),
        .freeze    (tick_freeze),
        .terminal  (tick_term),
        .term_next (tick_term_next)
    );

    // State and phase index registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: advance and instruction-boundary decisions are flagged first
    // and resolved once below so RUN and WAIT_IO share the same rules.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = 1'b0;
        tick_clear  = 1'b0;
        tick_freeze = 1'b0;
        do_adv      = 1'b0;
        do_bnd      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.step_mode) begin
                    state_d = WAIT_STEP;
                    idx_d   = '0;
                end else begin
                    state_d    = RUN;
                    idx_d      = '0;
                    start_d    = 1'b1;
                    tick_clear = 1'b1;
                end
            end
            RUN: begin
                if (tick_term) begin
                    if (idx_q == IO_IDX && bus.pause_req) begin
                        state_d     = WAIT_IO;
                        tick_freeze = 1'b1;
                    end else if (idx_q == LAST) begin
                        do_bnd = 1'b1;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            WAIT_IO: begin
                tick_freeze = 1'b1;
                // When IO_PHASE is the last phase the retirement was already
                // counted at its terminal tick; io_ack only resolves the boundary.
                if (bus.io_ack) begin
                    if (idx_q == LAST) begin
                        do_bnd = 1'b1;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            WAIT_STEP: begin
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (bus.step_pulse) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    start_d    = 1'b1;
                    tick_clear = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (do_adv) begin
            state_d     = RUN;
            idx_d       = idx_q + IW'(1);
            start_d     = 1'b1;
            tick_clear  = 1'b1;
            tick_freeze = 1'b0;
        end

        if (do_bnd) begin
            idx_d = '0;
            if (bus.halt) begin
                state_d = HALTED;
            end else if (bus.step_mode) begin
                state_d = WAIT_STEP;
            end else begin
                state_d     = RUN;
                start_d     = 1'b1;
                tick_clear  = 1'b1;
                tick_freeze = 1'b0;
            end
        end
    end

    // Output decode for the coming cycle; instr_done lines up with the last
    // phase's terminal tick.
    always_comb begin
        active_d = (state_d == RUN) || (state_d == WAIT_IO);
        done_d   = (state_d == RUN) && (idx_d == LAST) && tick_term_next;
        count_d  = done_d ? count_q + CNT_W'(1) : count_q;
        onehot_d = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            onehot_d[i] = active_d && (idx_d == IW'(i));
        end
    end

    // Registered outputs so nothing reaches the pins combinationally.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            onehot_q  <= '0;
            idx_out_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            waiting_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            onehot_q  <= onehot_d;
            idx_out_q <= active_d ? idx_d : '0;
            start_q   <= start_d;
            done_q    <= done_d;
            waiting_q <= (state_d == WAIT_IO);
            halted_q  <= (state_d == HALTED);
            count_q   <= count_d;
        end
    end

    assign bus.phase_onehot = onehot_q;
    assign bus.phase_idx    = idx_out_q;
    assign bus.phase_start  = start_q;
    assign bus.instr_done   = done_q;
    assign bus.waiting_io   = waiting_q;
    assign bus.halted       = halted_q;
    assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with a per-cycle expected-output queue.
// dut_a: 4 phases, 3 ticks, IO phase 2, 16-bit count.
// dut_b: 3 phases, 1 tick, 4-bit count (wrap check).
module tb_phase_sequencer;

    localparam int NP_A = 4, IO_A = 2, PT_A = 3, CW_A = 16;
    localparam int NP_B = 3, IO_B = 1, PT_B = 1, CW_B = 4;

    logic clk = 1'b0;
    logic n_reset_a, n_reset_b;

    always #5 clk = ~clk;

    phase_sequencer_if #(.NUM_PHASES(NP_A), .CNT_W(CW_A)) bus_a ();
    phase_sequencer_if #(.NUM_PHASES(NP_B), .CNT_W(CW_B)) bus_b ();

    phase_sequencer #(
        .NUM_PHASES(NP_A), .IO_PHASE(IO_A), .PHASE_TICKS(PT_A), .CNT_W(CW_A)
    ) dut_a (
        .clk     (clk),
        .n_reset (n_reset_a),
        .bus     (bus_a)
    );

    phase_sequencer #(
        .NUM_PHASES(NP_B), .IO_PHASE(IO_B), .PHASE_TICKS(PT_B), .CNT_W(CW_B)
    ) dut_b (
        .clk     (clk),
        .n_reset (n_reset_b),
        .bus     (bus_b)
    );

    typedef struct {
        int onehot;
        int idx;
        bit start;
        bit done;
        int count;
        bit wio;
        bit hlt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_count = 0;
    int   cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int oh, input int idx, input bit st, input bit dn,
                        input int cnt, input bit wio, input bit hlt);
        exp_t e;
        e.onehot = oh; e.idx = idx; e.start = st; e.done = dn;
        e.count = cnt; e.wio = wio; e.hlt = hlt;
        sb.push_back(e);
    endtask

    // Expected outputs for every clk of one phase in RUN.
    task automatic push_phase(input int p, input int np, input int pt, input int mask);
        for (int t = 0; t < pt; t++) begin
            bit d;
            d = (p == np - 1) && (t == pt - 1);
            if (d) exp_count = (exp_count + 1) & mask;
            push(1 << p, p, (t == 0), d, exp_count, 1'b0, 1'b0);
        end
    endtask

    task automatic push_instr(input int np, input int pt, input int mask);
        for (int p = 0; p < np; p++) push_phase(p, np, pt, mask);
    endtask

    task automatic compare(input exp_t e, input bit use_b);
        logic [31:0] oh, idx, cnt;
        logic        st, dn, wio, hlt;
        string       pfx;
        if (use_b) begin
            pfx = "b_";
            oh = 32'(bus_b.phase_onehot); idx = 32'(bus_b.phase_idx);
            cnt = 32'(bus_b.instr_count);
            st = bus_b.phase_start; dn = bus_b.instr_done;
            wio = bus_b.waiting_io; hlt = bus_b.halted;
        end else begin
            pfx = "a_";
            oh = 32'(bus_a.phase_onehot); idx = 32'(bus_a.phase_idx);
            cnt = 32'(bus_a.instr_count);
            st = bus_a.phase_start; dn = bus_a.instr_done;
            wio = bus_a.waiting_io; hlt = bus_a.halted;
        end
        chk({pfx, "phase_onehot"}, oh, e.onehot);
        chk({pfx, "phase_idx"}, idx, e.idx);
        chk({pfx, "phase_start"}, 32'(st), 32'(e.start));
        chk({pfx, "instr_done"}, 32'(dn), 32'(e.done));
        chk({pfx, "instr_count"}, cnt, e.count);
        chk({pfx, "waiting_io"}, 32'(wio), 32'(e.wio));
        chk({pfx, "halted"}, 32'(hlt), 32'(e.hlt));
    endtask

    // Advance n clks, popping one expected entry per clk.
    task automatic run(input int n, input bit use_b);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            n_chk++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_empty cycle=%0d observed=0 expected=nonzero queue depth", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare(e, use_b);
            end
        end
    endtask

    task automatic check_reset(input bit use_b, input string tag);
        exp_t e;
        e.onehot = 0; e.idx = 0; e.start = 0; e.done = 0;
        e.count = 0; e.wio = 0; e.hlt = 0;
        chk({tag, "_seen"}, 32'(1), 32'(1) & 32'(use_b ? !n_reset_b : !n_reset_a));
        compare(e, use_b);
    endtask

    initial begin
        n_reset_a = 1'b0;
        n_reset_b = 1'b0;
        bus_a.step_mode = 0; bus_a.step_pulse = 0; bus_a.pause_req = 0;
        bus_a.io_ack = 0; bus_a.halt = 0;
        bus_b.step_mode = 0; bus_b.step_pulse = 0; bus_b.pause_req = 0;
        bus_b.io_ack = 0; bus_b.halt = 0;

        @(posedge clk); #1;
        check_reset(1'b0, "a_reset");
        check_reset(1'b1, "b_reset");

        // Free-run: two instructions, 3 clks per phase.
        n_reset_a = 1'b1;
        exp_count = 0;
        push_instr(NP_A, PT_A, 'hFFFF);
        push_instr(NP_A, PT_A, 'hFFFF);
        run(24, 1'b0);

        // IO wait at phase 2, held 50 clks, then released by io_ack.
        bus_a.pause_req = 1'b1;
        push_phase(0, NP_A, PT_A, 'hFFFF);
        push_phase(1, NP_A, PT_A, 'hFFFF);
        push_phase(2, NP_A, PT_A, 'hFFFF);
        run(9, 1'b0);
        for (int i = 0; i < 50; i++) push(4'b0100, 2, 1'b0, 1'b0, exp_count, 1'b1, 1'b0);
        run(50, 1'b0);
        bus_a.pause_req = 1'b0;
        bus_a.io_ack = 1'b1;
        push_phase(3, NP_A, PT_A, 'hFFFF);
        run(1, 1'b0);
        bus_a.io_ack = 1'b0;
        run(2, 1'b0);

        // io_ack outside WAIT_IO changes nothing.
        push_instr(NP_A, PT_A, 'hFFFF);
        bus_a.io_ack = 1'b1;
        run(1, 1'b0);
        bus_a.io_ack = 1'b0;
        run(11, 1'b0);

        // Bring count to 5 and stop one clk into phase 2.
        push_instr(NP_A, PT_A, 'hFFFF);
        push_phase(0, NP_A, PT_A, 'hFFFF);
        push_phase(1, NP_A, PT_A, 'hFFFF);
        push_phase(2, NP_A, PT_A, 'hFFFF);
        run(19, 1'b0);
        chk("a_count_before_reset", 32'(bus_a.instr_count), 32'd5);

        // Asynchronous reset away from the clock edge.
        #2;
        n_reset_a = 1'b0;
        #1;
        check_reset(1'b0, "a_async_reset");
        sb.delete();
        @(posedge clk); #1;
        check_reset(1'b0, "a_reset_held");
        n_reset_a = 1'b1;
        exp_count = 0;
        push_phase(0, NP_A, PT_A, 'hFFFF);
        run(3, 1'b0);

        // Halt raised mid-phase 1: instruction completes then HALTED.
        push_phase(1, NP_A, PT_A, 'hFFFF);
        run(1, 1'b0);
        bus_a.halt = 1'b1;
        run(2, 1'b0);
        push_phase(2, NP_A, PT_A, 'hFFFF);
        push_phase(3, NP_A, PT_A, 'hFFFF);
        run(6, 1'b0);
        for (int i = 0; i < 6; i++) push(0, 0, 1'b0, 1'b0, exp_count, 1'b0, 1'b1);
        run(2, 1'b0);
        bus_a.step_pulse = 1'b1;
        bus_a.io_ack = 1'b1;
        bus_a.halt = 1'b0;
        run(1, 1'b0);
        bus_a.step_pulse = 1'b0;
        bus_a.io_ack = 1'b0;
        run(3, 1'b0);

        // Single-step from reset.
        n_reset_a = 1'b0;
        bus_a.step_mode = 1'b1;
        @(posedge clk); #1;
        check_reset(1'b0, "a_step_reset");
        n_reset_a = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 4; i++) push(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run(4, 1'b0);
        push_instr(NP_A, PT_A, 'hFFFF);
        bus_a.step_pulse = 1'b1;
        run(1, 1'b0);
        bus_a.step_pulse = 1'b0;
        run(4, 1'b0);
        bus_a.step_pulse = 1'b1;
        run(1, 1'b0);
        bus_a.step_pulse = 1'b0;
        run(6, 1'b0);
        for (int i = 0; i < 5; i++) push(0, 0, 1'b0, 1'b0, exp_count, 1'b0, 1'b0);
        run(5, 1'b0);

        // Halt beats a simultaneous step_pulse in WAIT_STEP.
        bus_a.halt = 1'b1;
        bus_a.step_pulse = 1'b1;
        for (int i = 0; i < 3; i++) push(0, 0, 1'b0, 1'b0, exp_count, 1'b0, 1'b1);
        run(1, 1'b0);
        bus_a.halt = 1'b0;
        bus_a.step_pulse = 1'b0;
        run(2, 1'b0);

        // One-tick phases, 3 phases, 4-bit counter wraps after 16 instructions.
        n_reset_b = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 16; i++) push_instr(NP_B, PT_B, 'hF);
        run(48, 1'b1);
        chk("b_count_wrapped", 32'(bus_b.instr_count), 32'd0);
        chk("b_queue_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised instruction-phase generator for the multi-cycle datapath, generalising the fixed four-phase cycle generator.
- Produces NUM_PHASES one-hot phase enables plus a single-clk phase_start strobe per phase entry, all in the clk domain, so no derived phase clocks are needed.
- Adds programmable phase length, an IO wait handshake, single-step mode, halt latching and a retired-instruction counter.
- Sits between the debounced board inputs (step button, IO button) and the PC, register files, memories and output display.

Parameters:
NUM_PHASES, 4, phases per instruction; legal range >= 2.
IO_PHASE, 2, phase index at which the IO wait is sampled; must be < NUM_PHASES.
PHASE_TICKS, 1000, clk cycles per phase; legal range >= 1.
CNT_W, 16, width of instr_count.

Ports:
clk  in  1  system clock.
n_reset  in  1  asynchronous active-low reset.
step_mode  in  1  1 = single-step, 0 = free-run; sampled only at instruction boundaries.
step_pulse  in  1  single-clk pulse from the debounced step button.
pause_req  in  1  control unit requests an IO wait at the current instruction.
io_ack  in  1  single-clk pulse from the debounced IO button; releases the IO wait.
halt  in  1  halt request (control unit halt OR input halt).
phase_onehot  out  NUM_PHASES  active phase; all zero when no phase is active.
phase_idx  out  $clog2(NUM_PHASES)  index of the active phase; 0 when idle.
phase_start  out  1  one-clk strobe in the first clk of every phase.
instr_done  out  1  one-clk strobe when the last phase completes.
waiting_io  out  1  high while in WAIT_IO.
halted  out  1  high while in HALTED.
instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, RUN, WAIT_IO, WAIT_STEP, HALTED.
- Reset (async, n_reset=0): state IDLE, tick=0, phase_onehot=0, phase_idx=0, phase_start=0, instr_done=0, waiting_io=0, halted=0, instr_count=0.
- IDLE:
  - step_mode=0: at the first clk edge after reset release, enter RUN at phase 0 with phase_start=1.
  - step_mode=1: enter WAIT_STEP instead.
- RUN:
  - tick counts 0..PHASE_TICKS-1; phase_onehot is held for exactly PHASE_TICKS clks.
  - At terminal tick of phase p < NUM_PHASES-1:
    - if p==IO_PHASE and pause_req=1, go to WAIT_IO and hold phase p;
    - otherwise move to phase p+1 with phase_start=1 on the next clk.
- Terminal tick of the last phase (instruction boundary):
  - instr_done=1 for one clk and instr_count+1 on the same edge.
  - Next state by priority: halt=1 -> HALTED; else step_mode=1 -> WAIT_STEP; else phase 0 with phase_start=1.
- WAIT_IO:
  - phase_onehot holds IO_PHASE; waiting_io=1; tick frozen.
  - io_ack=1 is treated as that phase's terminal tick: normal advance or boundary rules apply on the next clk, so IO_PHASE==NUM_PHASES-1 also evaluates halt and step.
  - io_ack in any other state is ignored; pause_req outside the IO_PHASE terminal tick is ignored.
- WAIT_STEP:
  - phase_onehot=0, phase_idx=0.
  - step_pulse=1 -> phase 0 with phase_start=1.
  - halt=1 while waiting -> HALTED; halt wins over a simultaneous step_pulse.
- HALTED:
  - phase_onehot=0, halted=1; all inputs ignored.
  - Exit only via n_reset.
- PHASE_TICKS=1: phases advance every clk; phase_start is high every clk during RUN.
- Reset mid-phase or in any state: immediate return to IDLE values; no instr_done is emitted.
- All outputs are registered; none are combinational from inputs.

Decomposition:
- Shared package: state encoding enum (IDLE, RUN, WAIT_IO, WAIT_STEP, HALTED) and the phase-index width function, so the datapath decodes the same constants.
- One natural sub-module: phase_tick_counter (PHASE_TICKS prescaler with clear/freeze inputs and a terminal-tick output). The FSM stays in the parent.

Test Plan:
1. Free-run, NUM_PHASES=4, PHASE_TICKS=3, no stimulus:
   - phase_onehot cycles 0001->0010->0100->1000, each held 3 clks;
   - phase_start at clks 1,4,7,10; instr_done at clk 12; instr_count=1 after 12 clks, 2 after 24.
2. IO wait, IO_PHASE=2, pause_req=1 at phase 2 terminal:
   - phase_onehot stays 0100 and waiting_io=1 for 50 clks without io_ack;
   - io_ack pulse -> next clk 1000 with phase_start=1, waiting_io=0.
3. Step mode, step_mode=1 from reset:
   - WAIT_STEP with phase_onehot=0;
   - step_pulse -> exactly one instruction (4 phases, one instr_done), then back to WAIT_STEP;
   - extra step_pulse during RUN is ignored.
4. Halt at boundary, halt=1 asserted mid-phase 1:
   - instruction completes through phase 3, instr_done=1, instr_count increments, halted=1, phase_onehot=0;
   - step_pulse and io_ack have no effect afterwards.
5. Async reset mid-phase 2 with instr_count=5:
   - outputs return to reset values immediately, without waiting for clk;
   - after release, phase 0 restarts with instr_count=0.
6. Wrap and generics, CNT_W=4, PHASE_TICKS=1, NUM_PHASES=3:
   - after 16 instructions instr_count=0;
   - phase_start high every RUN clk; phase_onehot sequence 001,010,100.
